trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Machine-mode trap sequencer for the RV32I pipeline.
- Consumes the decoder's exception flags and MRET indication for the instruction in the XB stage.
- On a trap or MRET: captures mepc/mcause/mtval, flushes the front-end for a fixed number of cycles, then issues a PC redirect to fetch through a valid/ready handshake.
- Owns the trap CSRs (mstatus.MIE/MPIE, mtvec, mepc, mcause, mtval) behind a simple CSR read/write port.

Parameters:
- RESET_MTVEC, 32'h0000_0004, mtvec value after reset (bits [1:0] forced 0).
- FLUSH_CYCLES, 2, cycles of flush before redirect; legal range 1..15.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- xb_valid  in  1  XB stage holds a valid instruction
- xb_pc  in  32  PC of XB instruction
- xb_inst  in  32  raw XB instruction
- xb_addr  in  32  effective data address (rs1+imm) of XB instruction
- exc_unsupported  in  1  decoder exception_unsupported_category
- exc_illegal  in  1  decoder exception_illegal_instruction
- exc_load_misaligned  in  1  decoder exception_load_misaligned
- exc_store_misaligned  in  1  decoder exception_store_misaligned
- xb_mret  in  1  decoder pc_mepc
- csr_addr  in  12  CSR address
- csr_we  in  1  CSR write strobe, already resolved by the CSR unit (write/set/clear applied)
- csr_wdata  in  32  CSR write value
- csr_rdata  out  32  combinational read of csr_addr; 0 for unowned addresses
- csr_hit  out  1  csr_addr is owned by this block
- xb_kill  out  1  combinational: cancel the XB instruction's memory write and CSR write this cycle
- flush  out  1  invalidate IF/ID stage contents
- stall  out  1  hold PC and pipeline registers
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts the redirect
- trap_taken  out  1  one-cycle pulse, the cycle after a trap is accepted
- mstatus_mie  out  1  current MIE bit

Behaviour:
- Reset values:
  - state RUN.
  - All outputs 0, except csr_rdata (combinational).
  - mtvec = RESET_MTVEC & ~3.
  - mepc, mcause, mtval = 0; MIE = 0; MPIE = 0.
- States:
  - RUN, FLUSH, REDIRECT.
  - In FLUSH and REDIRECT: stall=1. flush=1 in FLUSH only.
- Trap detection (RUN only):
  - exc_any = xb_valid & (any exc_* flag).
  - xb_kill = exc_any | (xb_valid & xb_mret); combinational, same cycle.
- Trap accept, at the edge ending cycle N where exc_any=1:
  - mepc <= xb_pc & ~3.
  - mcause/mtval by priority:
    - unsupported or illegal: mcause=2, mtval=xb_inst.
    - else load misaligned: mcause=4, mtval=xb_addr.
    - else store misaligned: mcause=6, mtval=xb_addr.
  - MPIE <= MIE; MIE <= 0.
  - target <= mtvec; state <= FLUSH; cnt <= FLUSH_CYCLES-1.
  - trap_taken=1 in cycle N+1 only.
- MRET accept (xb_valid & xb_mret & ~exc_any):
  - MIE <= MPIE; MPIE <= 1.
  - target <= mepc; state <= FLUSH; trap_taken stays 0.
- Exception and MRET in the same cycle: exception wins.
- FLUSH:
  - cnt decrements each cycle.
  - When cnt==0, move to REDIRECT next cycle, so flush lasts exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target, held stable until redirect_ready=1.
  - On the handshake cycle, state returns to RUN next cycle.
  - No timeout.
- Exception flags and xb_mret are ignored outside RUN (the pipeline is stalled).
- CSR map:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE, other bits read 0.
  - 0x305 mtvec: bits[1:0] read-only 0, direct mode only.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause.
  - 0x343 mtval.
- CSR writes take effect at the edge, only when csr_we & ~xb_kill & state==RUN.
- A trap or MRET update in the same cycle overrides any CSR write.
- Reset during FLUSH or REDIRECT: return to RUN next cycle, redirect dropped, all CSRs at reset values.

Decomposition:
- Shared package/header (alongside opcode/aluop definitions):
  - CSR address constants: CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL.
  - Cause codes: CAUSE_ILLEGAL=2, CAUSE_LOAD_MISALIGNED=4, CAUSE_STORE_MISALIGNED=6.
  - State encodings.
- One natural sub-module: trap_csr_file (CSR storage, read mux, write priority). The FSM stays in trap_controller.

Test Plan:
- Illegal trap: xb_valid=1, exc_illegal=1, xb_pc=0x100, xb_inst=0xFFFF_FFFF -> same-cycle xb_kill=1; next cycle trap_taken=1, mepc=0x100, mcause=2, mtval=0xFFFF_FFFF; flush high 2 cycles; then redirect_pc=0x4.
- Misaligned priority: exc_load_misaligned=1 with exc_illegal=1, xb_addr=0x2001 -> mcause=2; repeat with exc_load_misaligned only -> mcause=4, mtval=0x2001.
- MRET: write mepc=0x203 via CSR port (reads back 0x200), set MPIE=1, assert xb_mret -> redirect_pc=0x200, MIE=1, trap_taken stays 0.
- Redirect backpressure: hold redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid and redirect_pc stable, stall=1; raise ready -> RUN next cycle.
- CSR write vs trap: write mtvec=0x8003 in the same cycle as exc_illegal -> write dropped, mtvec unchanged; write 0x8003 in RUN -> reads 0x8000.
- Reset mid-flush: assert reset in FLUSH cycle 1 -> next cycle state RUN, flush=0, redirect_valid=0, mtvec=0x4, mepc=0.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// cause codes, sequencer states and the CSR ownership decode.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  function automatic logic csr_owned(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MEPC) ||
           (addr == CSR_MCAUSE)  || (addr == CSR_MTVAL);
  endfunction

endpackage

// File: rtl/trap_controller_csr_file.sv
// Trap CSR storage (mstatus MIE/MPIE, mtvec, mepc, mcause, mtval) with
// combinational read mux; trap and MRET updates take priority over CSR writes.
module trap_csr_file
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_accept,
  input  logic        mret_accept,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mie
);

  localparam logic [31:0] MTVEC_INIT = RESET_MTVEC & 32'hFFFF_FFFC;

  logic        mie_reg;
  logic        mpie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_reg    <= 1'b0;
      mpie_reg   <= 1'b0;
      mtvec_reg  <= MTVEC_INIT;
      mepc_reg   <= 32'd0;
      mcause_reg <= 32'd0;
      mtval_reg  <= 32'd0;
    end else if (trap_accept) begin
      mepc_reg   <= trap_pc & 32'hFFFF_FFFC;
      mcause_reg <= trap_cause;
      mtval_reg  <= trap_tval;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret_accept) begin
      mie_reg    <= mpie_reg;
      mpie_reg   <= 1'b1;
    end else if (csr_we) begin
      // Low two bits of mtvec/mepc are hardwired zero (direct mode, 4-byte aligned).
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_reg  <= csr_wdata[MSTATUS_MIE_BIT];
          mpie_reg <= csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:  mtvec_reg  <= csr_wdata & 32'hFFFF_FFFC;
        CSR_MEPC:   mepc_reg   <= csr_wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE: mcause_reg <= csr_wdata;
        CSR_MTVAL:  mtval_reg  <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mie_reg;
        csr_rdata[MSTATUS_MPIE_BIT] = mpie_reg;
      end
      CSR_MTVEC:  csr_rdata = mtvec_reg;
      CSR_MEPC:   csr_rdata = mepc_reg;
      CSR_MCAUSE: csr_rdata = mcause_reg;
      CSR_MTVAL:  csr_rdata = mtval_reg;
      default: ;
    endcase
  end

  assign csr_hit = csr_owned(csr_addr);
  assign mtvec   = mtvec_reg;
  assign mepc    = mepc_reg;
  assign mie     = mie_reg;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: accepts exceptions/MRET from XB, flushes the
// front-end for FLUSH_CYCLES cycles, then hands a redirect PC to fetch.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0004,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xb_valid,
  input  logic [31:0] xb_pc,
  input  logic [31:0] xb_inst,
  input  logic [31:0] xb_addr,
  input  logic        exc_unsupported,
  input  logic        exc_illegal,
  input  logic        exc_load_misaligned,
  input  logic        exc_store_misaligned,
  input  logic        xb_mret,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        xb_kill,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        trap_taken,
  output logic        mstatus_mie
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  trap_state_e state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] target_reg, target_next;
  logic        trap_taken_reg;

  logic        in_run, exc_any, mret_req;
  logic        trap_accept, mret_accept, csr_we_ok;
  logic [31:0] trap_cause, trap_tval, mtvec, mepc;

  assign in_run      = (state_reg == ST_RUN);
  assign exc_any     = xb_valid & (exc_unsupported | exc_illegal |
                                   exc_load_misaligned | exc_store_misaligned);
  assign mret_req    = xb_valid & xb_mret;
  assign trap_accept = in_run & exc_any;
  assign mret_accept = in_run & mret_req & ~exc_any;
  assign xb_kill     = in_run & (exc_any | mret_req);
  assign csr_we_ok   = csr_we & ~xb_kill & in_run;

  always_comb begin
    trap_cause = CAUSE_STORE_MISALIGNED;
    trap_tval  = xb_addr;
    if (exc_unsupported | exc_illegal) begin
      trap_cause = CAUSE_ILLEGAL;
      trap_tval  = xb_inst;
    end else if (exc_load_misaligned) begin
      trap_cause = CAUSE_LOAD_MISALIGNED;
    end
  end

  trap_csr_file #(
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk         (clk),
    .reset       (reset),
    .trap_accept (trap_accept),
    .mret_accept (mret_accept),
    .trap_pc     (xb_pc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .csr_addr    (csr_addr),
    .csr_we      (csr_we_ok),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_hit     (csr_hit),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .mie         (mstatus_mie)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    target_next    = target_reg;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state_reg)
      ST_RUN: begin
        if (trap_accept || mret_accept) begin
          state_next  = ST_FLUSH;
          cnt_next    = CNT_INIT;
          target_next = trap_accept ? mtvec : mepc;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        stall = 1'b1;
        if (cnt_reg == 4'd0) state_next = ST_REDIRECT;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_reg;
        if (redirect_ready) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      cnt_reg        <= 4'd0;
      target_reg     <= 32'd0;
      trap_taken_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      target_reg     <= target_next;
      trap_taken_reg <= trap_accept;
    end
  end

  assign trap_taken = trap_taken_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed trap/MRET/backpressure/reset
// sequences and table vectors, plus random traffic against a behavioural model.
module tb_trap_controller;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        xb_valid, xb_mret;
  logic [31:0] xb_pc, xb_inst, xb_addr;
  logic        exc_unsupported, exc_illegal, exc_load_misaligned, exc_store_misaligned;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit, xb_kill, flush, stall, redirect_valid, trap_taken, mstatus_mie;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  trap_controller #(.RESET_MTVEC(32'h0000_0004), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .xb_valid(xb_valid), .xb_pc(xb_pc), .xb_inst(xb_inst),
    .xb_addr(xb_addr), .exc_unsupported(exc_unsupported), .exc_illegal(exc_illegal),
    .exc_load_misaligned(exc_load_misaligned), .exc_store_misaligned(exc_store_misaligned),
    .xb_mret(xb_mret), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_hit(csr_hit), .xb_kill(xb_kill), .flush(flush),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_taken(trap_taken), .mstatus_mie(mstatus_mie)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: architectural CSR values plus "flush cycles left" and
  // "redirect pending" describing where the trap sequence currently is.
  logic        m_mie, m_mpie, m_redir, m_pulse;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_target;
  int          m_flush_left;

  typedef struct {
    logic [3:0]  exc;      // {unsupported, illegal, load_mis, store_mis}
    logic [31:0] pc, inst, addr;
    logic [31:0] exp_cause, exp_tval, exp_epc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 32'h4; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_target = 0; m_flush_left = 0; m_redir = 0; m_pulse = 0;
  endtask

  task automatic clear_in();
    xb_valid = 0; xb_mret = 0; xb_pc = 0; xb_inst = 0; xb_addr = 0;
    exc_unsupported = 0; exc_illegal = 0; exc_load_misaligned = 0; exc_store_misaligned = 0;
    csr_addr = 0; csr_we = 0; csr_wdata = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Compare every output to the model for the current cycle, then clock and advance the model.
  task automatic cycle(input string tag);
    logic run, exc, kill_e, hit_e;
    #1;
    run    = (m_flush_left == 0) && !m_redir;
    exc    = xb_valid & (exc_unsupported | exc_illegal | exc_load_misaligned | exc_store_misaligned);
    kill_e = run & (exc | (xb_valid & xb_mret));
    hit_e  = (csr_addr == 12'h300) || (csr_addr == 12'h305) || (csr_addr == 12'h341) ||
             (csr_addr == 12'h342) || (csr_addr == 12'h343);
    chk({tag, ".kill"},  xb_kill, kill_e);
    chk({tag, ".flush"}, flush, m_flush_left > 0);
    chk({tag, ".stall"}, stall, !run);
    chk({tag, ".rvalid"}, redirect_valid, m_redir);
    if (m_redir) chk({tag, ".rpc"}, redirect_pc, m_target);
    chk({tag, ".trap_taken"}, trap_taken, m_pulse);
    chk({tag, ".mie"}, mstatus_mie, m_mie);
    chk({tag, ".rdata"}, csr_rdata, m_read(csr_addr));
    chk({tag, ".hit"}, csr_hit, hit_e);
    if (reset) begin
      m_reset();
    end else if (run) begin
      m_pulse = 0;
      if (exc) begin
        m_mepc = xb_pc & 32'hFFFF_FFFC;
        if (exc_unsupported | exc_illegal) begin m_mcause = 2; m_mtval = xb_inst; end
        else if (exc_load_misaligned)      begin m_mcause = 4; m_mtval = xb_addr; end
        else                               begin m_mcause = 6; m_mtval = xb_addr; end
        m_mpie = m_mie; m_mie = 0; m_target = m_mtvec; m_flush_left = FC; m_pulse = 1;
      end else if (xb_valid & xb_mret) begin
        m_mie = m_mpie; m_mpie = 1; m_target = m_mepc; m_flush_left = FC;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
          12'h305: m_mtvec  = csr_wdata & 32'hFFFF_FFFC;
          12'h341: m_mepc   = csr_wdata & 32'hFFFF_FFFC;
          12'h342: m_mcause = csr_wdata;
          12'h343: m_mtval  = csr_wdata;
          default: ;
        endcase
      end
    end else begin
      m_pulse = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) m_redir = 1;
      end else if (redirect_ready) begin
        m_redir = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redirect(output int nf);
    nf = 0;
    for (int k = 0; k < 20; k++) begin
      if (redirect_valid) break;
      if (flush) nf++;
      cycle("wait");
    end
    chk("redirect_seen", redirect_valid, 1);
  endtask

  task automatic accept_redirect();
    redirect_ready = 1;
    cycle("accept");
    redirect_ready = 0;
    chk("back_to_run.stall", stall, 0);
  endtask

  initial begin
    int nf;
    logic [11:0] addrs[6];
    vecs[0] = '{4'b0100, 32'h100, 32'hFFFF_FFFF, 32'h0,    32'd2, 32'hFFFF_FFFF, 32'h100};
    vecs[1] = '{4'b0110, 32'h104, 32'h0000_1234, 32'h2001, 32'd2, 32'h0000_1234, 32'h104};
    vecs[2] = '{4'b0010, 32'h108, 32'h0000_5555, 32'h2001, 32'd4, 32'h2001,      32'h108};
    vecs[3] = '{4'b0001, 32'h10E, 32'h0000_6666, 32'h3003, 32'd6, 32'h3003,      32'h10C};
    vecs[4] = '{4'b1001, 32'h111, 32'h0000_ABCD, 32'h3003, 32'd2, 32'h0000_ABCD, 32'h110};
    addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h001};

    clear_in();
    redirect_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    cycle("reset");
    reset = 0;
    chk("reset.mtvec", dut.csr_rdata, 32'h0);  // csr_addr=0 is unowned
    rd("reset.mtvec_rd", 12'h305, 32'h4);
    rd("reset.mepc_rd", 12'h341, 32'h0);

    // Table: one exception per row; expected CSR capture values are fixed in the table.
    for (int i = 0; i < 5; i++) begin
      clear_in();
      xb_valid = 1; xb_pc = vecs[i].pc; xb_inst = vecs[i].inst; xb_addr = vecs[i].addr;
      {exc_unsupported, exc_illegal, exc_load_misaligned, exc_store_misaligned} = vecs[i].exc;
      #1;
      chk("vec.kill_same_cycle", xb_kill, 1);
      cycle("vec.trap");
      clear_in();
      chk("vec.trap_taken", trap_taken, 1);
      rd("vec.mcause", 12'h342, vecs[i].exp_cause);
      rd("vec.mtval", 12'h343, vecs[i].exp_tval);
      rd("vec.mepc", 12'h341, vecs[i].exp_epc);
      wait_redirect(nf);
      chk("vec.flush_cycles", nf, FC);
      chk("vec.redirect_pc", redirect_pc, 32'h4);
      accept_redirect();
      $display("vec %0d: exc=%b cause=%0d tval=%h epc=%h", i, vecs[i].exc,
               vecs[i].exp_cause, vecs[i].exp_tval, vecs[i].exp_epc);
    end

    // MRET with redirect backpressure.
    clear_in();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h203;
    cycle("mret.wr_mepc");
    csr_we = 0;
    rd("mret.mepc_rd", 12'h341, 32'h200);
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h80;
    cycle("mret.wr_mstatus");
    clear_in();
    xb_valid = 1; xb_mret = 1;
    cycle("mret.accept");
    clear_in();
    chk("mret.trap_taken", trap_taken, 0);
    chk("mret.mie", mstatus_mie, 1);
    wait_redirect(nf);
    for (int k = 0; k < 5; k++) begin
      chk("bp.rvalid", redirect_valid, 1);
      chk("bp.rpc", redirect_pc, 32'h200);
      chk("bp.stall", stall, 1);
      cycle("bp.hold");
    end
    accept_redirect();
    chk("bp.rvalid_after", redirect_valid, 0);
    $display("mret: redirect to %h after backpressure", 32'h200);

    // CSR write colliding with a trap is dropped; a plain write lands aligned.
    clear_in();
    xb_valid = 1; exc_illegal = 1; xb_pc = 32'h300; xb_inst = 32'h13;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h8003;
    cycle("csrtrap.collide");
    clear_in();
    rd("csrtrap.mtvec_kept", 12'h305, 32'h4);
    wait_redirect(nf);
    accept_redirect();
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h8003;
    cycle("csrtrap.write");
    csr_we = 0;
    rd("csrtrap.mtvec_new", 12'h305, 32'h8000);
    $display("csr: mtvec write during trap dropped, later write reads %h", 32'h8000);

    // Reset during the first flush cycle.
    clear_in();
    xb_valid = 1; exc_load_misaligned = 1; xb_pc = 32'h440; xb_addr = 32'h11;
    cycle("rstflush.trap");
    clear_in();
    chk("rstflush.in_flush", flush, 1);
    reset = 1;
    cycle("rstflush.reset");
    reset = 0;
    chk("rstflush.flush", flush, 0);
    chk("rstflush.rvalid", redirect_valid, 0);
    chk("rstflush.stall", stall, 0);
    rd("rstflush.mtvec", 12'h305, 32'h4);
    rd("rstflush.mepc", 12'h341, 32'h0);
    $display("reset mid-flush: back in run");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      xb_valid             = ($urandom_range(3) != 0);
      xb_pc                = $urandom;
      xb_inst              = $urandom;
      xb_addr              = $urandom;
      exc_unsupported      = ($urandom_range(15) == 0);
      exc_illegal          = ($urandom_range(15) == 0);
      exc_load_misaligned  = ($urandom_range(15) == 0);
      exc_store_misaligned = ($urandom_range(15) == 0);
      xb_mret              = ($urandom_range(7) == 0);
      csr_addr             = addrs[$urandom_range(5)];
      csr_we               = ($urandom_range(1) == 0);
      csr_wdata            = $urandom;
      redirect_ready       = ($urandom_range(1) == 0);
      reset                = ($urandom_range(199) == 0);
      cycle("rand");
      if (n % 500 == 499) $display("random: %0d cycles checked", n + 1);
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
